// File: rtl/parity_err_monitor.sv
// Odd-parity checker for the parity generator's output stream.
// Each accepted beat is forwarded one cycle later with a per-group mismatch flag.
// Sticky per-group status, a saturating errored-beat counter and a level interrupt
// are kept until software pulses i_clr. With HALT_ON_ERR set, intake stops after
// an errored beat until i_clr.
//
// Handshake: a beat is accepted on a rising edge where i_valid & o_ready are both 1.
// o_ready depends only on the FSM state, never on i_valid. The output side has no
// backpressure, and o_valid is a one-cycle pulse per accepted beat.
module parity_err_monitor #(
    parameter int DATA_WIDTH   = 32,
    parameter int PARITY_WIDTH = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int HALT_ON_ERR  = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [PARITY_WIDTH-1:0] i_parity,
    input  logic                    i_irq_en,
    input  logic                    i_clr,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [PARITY_WIDTH-1:0] o_err,
    output logic [PARITY_WIDTH-1:0] o_err_vec,
    output logic [CNT_WIDTH-1:0]    o_err_cnt,
    output logic                    o_irq,
    output logic                    o_state      // debug: 0 = RUN, 1 = HALT
);

    localparam int G = DATA_WIDTH / PARITY_WIDTH;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [PARITY_WIDTH-1:0] err_q;
    logic [PARITY_WIDTH-1:0] err_vec_q, err_vec_d;
    logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic                    irq_q, irq_d;

    logic                    ready;
    logic                    accept;
    logic [PARITY_WIDTH-1:0] mismatch;
    logic                    beat_err;

    // Per-group odd-parity check: the group bits XORed with their parity bit must be 1.
    always_comb begin
        mismatch = '0;
        for (int k = 0; k < PARITY_WIDTH; k++) begin
            mismatch[k] = ~^{i_data[k*G +: G], i_parity[k]};
        end
    end

    assign accept   = i_valid & ready;
    assign beat_err = accept & (|mismatch);

    // FSM next-state and ready decode; only halts when HALT_ON_ERR is enabled.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_RUN: begin
                ready = 1'b1;
                if ((HALT_ON_ERR != 0) && beat_err) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                ready = 1'b0;
                if (i_clr) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                ready   = 1'b0;
            end
        endcase
    end

    // Status next-state: a new error in the same cycle as i_clr wins over the clear.
    always_comb begin
        err_vec_d = i_clr ? '0 : err_vec_q;
        err_cnt_d = err_cnt_q;
        if (beat_err) begin
            err_vec_d = err_vec_d | mismatch;
            if (i_clr) begin
                err_cnt_d = CNT_WIDTH'(1);
            end else if (err_cnt_q != {CNT_WIDTH{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
        end else if (i_clr) begin
            err_cnt_d = '0;
        end
        // The interrupt follows the registered status one cycle later; a clear that
        // races a new error keeps an already-raised interrupt from dropping.
        if (i_clr) begin
            irq_d = i_irq_en & beat_err & (|err_vec_q);
        end else begin
            irq_d = i_irq_en & (|err_vec_q);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Output beat register; data and flags hold while no beat is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                data_q <= i_data;
                err_q  <= mismatch;
            end
        end
    end

    // Sticky status, counter and interrupt registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_vec_q <= '0;
            err_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            err_vec_q <= err_vec_d;
            err_cnt_q <= err_cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign o_ready   = ready;
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_err     = err_q;
    assign o_err_vec = err_vec_q;
    assign o_err_cnt = err_cnt_q;
    assign o_irq     = irq_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_parity_err_monitor.sv
// Bench for parity_err_monitor: three instances share one input stream
// (default, 2-bit counter, halt-on-error) and are compared every cycle against
// a behavioural model, plus directed checks at the interesting points.
module tb_parity_err_monitor;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    logic        i_valid;
    logic [31:0] i_data;
    logic [3:0]  i_parity;
    logic        i_irq_en;
    logic        i_clr;

    logic rdy_a, vld_a, irq_a, st_a;
    logic rdy_s, vld_s, irq_s, st_s;
    logic rdy_h, vld_h, irq_h, st_h;
    logic [31:0] dat_a, dat_s, dat_h;
    logic [3:0]  err_a, err_s, err_h, vec_a, vec_s, vec_h;
    logic [7:0]  cnt_a, cnt_h;
    logic [1:0]  cnt_s;

    parity_err_monitor dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(rdy_a),
        .i_data(i_data), .i_parity(i_parity), .i_irq_en(i_irq_en), .i_clr(i_clr),
        .o_valid(vld_a), .o_data(dat_a), .o_err(err_a), .o_err_vec(vec_a),
        .o_err_cnt(cnt_a), .o_irq(irq_a), .o_state(st_a)
    );

    parity_err_monitor #(.CNT_WIDTH(2)) dut_s (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(rdy_s),
        .i_data(i_data), .i_parity(i_parity), .i_irq_en(i_irq_en), .i_clr(i_clr),
        .o_valid(vld_s), .o_data(dat_s), .o_err(err_s), .o_err_vec(vec_s),
        .o_err_cnt(cnt_s), .o_irq(irq_s), .o_state(st_s)
    );

    parity_err_monitor #(.HALT_ON_ERR(1)) dut_h (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(rdy_h),
        .i_data(i_data), .i_parity(i_parity), .i_irq_en(i_irq_en), .i_clr(i_clr),
        .o_valid(vld_h), .o_data(dat_h), .o_err(err_h), .o_err_vec(vec_h),
        .o_err_cnt(cnt_h), .o_irq(irq_h), .o_state(st_h)
    );

    // Gather instance outputs for indexed checking.
    logic        w_rdy[3], w_vld[3], w_irq[3], w_st[3];
    logic [31:0] w_dat[3];
    logic [3:0]  w_err[3], w_vec[3];
    logic [7:0]  w_cnt[3];
    always_comb begin
        w_rdy[0] = rdy_a; w_rdy[1] = rdy_s; w_rdy[2] = rdy_h;
        w_vld[0] = vld_a; w_vld[1] = vld_s; w_vld[2] = vld_h;
        w_irq[0] = irq_a; w_irq[1] = irq_s; w_irq[2] = irq_h;
        w_st[0]  = st_a;  w_st[1]  = st_s;  w_st[2]  = st_h;
        w_dat[0] = dat_a; w_dat[1] = dat_s; w_dat[2] = dat_h;
        w_err[0] = err_a; w_err[1] = err_s; w_err[2] = err_h;
        w_vec[0] = vec_a; w_vec[1] = vec_s; w_vec[2] = vec_h;
        w_cnt[0] = cnt_a; w_cnt[1] = {6'b0, cnt_s}; w_cnt[2] = cnt_h;
    end

    // ---------------- scoreboard / model ----------------
    int errors = 0;
    int checks = 0;

    int cnt_max[3]  = '{255, 3, 255};
    bit halt_en[3]  = '{1'b0, 1'b0, 1'b1};
    bit          m_halt[3];
    logic        m_valid[3];
    logic [31:0] m_data[3];
    logic [3:0]  m_err[3];
    logic [3:0]  m_vec[3];
    int          m_cnt[3];
    logic        m_irq[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Groups whose bit count (data plus parity bit) is even violate odd parity.
    function automatic logic [3:0] mism(input logic [31:0] d, input logic [3:0] p);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k] = (($countones(d[k*8 +: 8]) + int'(p[k])) % 2) == 0;
        end
        return r;
    endfunction

    function automatic logic [3:0] good_par(input logic [31:0] d);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) begin
            p[k] = ($countones(d[k*8 +: 8]) % 2) == 0;
        end
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_halt[i] = 0; m_valid[i] = 0; m_data[i] = 0; m_err[i] = 0;
            m_vec[i] = 0; m_cnt[i] = 0; m_irq[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] mm, vold;
        bit acc, err;
        for (int i = 0; i < 3; i++) begin
            acc  = i_valid && !m_halt[i];
            mm   = mism(i_data, i_parity);
            err  = acc && (mm != 0);
            vold = m_vec[i];
            m_valid[i] = acc;
            if (acc) begin
                m_data[i] = i_data;
                m_err[i]  = mm;
            end
            m_vec[i] = (i_clr ? 4'h0 : vold) | (err ? mm : 4'h0);
            if (err) m_cnt[i] = i_clr ? 1 : (m_cnt[i] < cnt_max[i] ? m_cnt[i] + 1 : m_cnt[i]);
            else if (i_clr) m_cnt[i] = 0;
            m_irq[i] = i_irq_en && (i_clr ? (err && vold != 0) : (vold != 0));
            if (halt_en[i] && err) m_halt[i] = 1;
            else if (i_clr) m_halt[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ready[%0d]", i), 32'(w_rdy[i]), 32'(!m_halt[i]));
            chk($sformatf("valid[%0d]", i), 32'(w_vld[i]), 32'(m_valid[i]));
            chk($sformatf("data[%0d]", i),  w_dat[i], m_data[i]);
            chk($sformatf("err[%0d]", i),   32'(w_err[i]), 32'(m_err[i]));
            chk($sformatf("vec[%0d]", i),   32'(w_vec[i]), 32'(m_vec[i]));
            chk($sformatf("cnt[%0d]", i),   32'(w_cnt[i]), 32'(m_cnt[i]));
            chk($sformatf("irq[%0d]", i),   32'(w_irq[i]), 32'(m_irq[i]));
            chk($sformatf("state[%0d]", i), 32'(w_st[i]),  32'(m_halt[i]));
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check_all();
    endtask

    // ---------------- directed + random sequence ----------------
    int exp_sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_parity = '0;
        i_irq_en = 1'b0; i_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_all();
        chk("reset_ready", 32'(rdy_a), 32'd1);
        chk("reset_valid", 32'(vld_a), 32'd0);
        i_rst_n = 1'b1;
        cycle();

        // Clean back-to-back stream.
        for (int n = 0; n < 16; n++) begin
            i_valid  = 1'b1;
            i_data   = (n % 2 == 1) ? 32'h1 : 32'h0;
            i_parity = (n % 2 == 1) ? 4'hE : 4'hF;
            cycle();
            chk("clean_valid", 32'(vld_a), 32'd1);
            chk("clean_err", 32'(err_a), 32'd0);
        end
        i_valid = 1'b0;
        cycle();
        chk("clean_cnt", 32'(cnt_a), 32'd0);
        chk("clean_idle_valid", 32'(vld_a), 32'd0);

        // Single group-0 error with interrupt enabled.
        i_irq_en = 1'b1; i_valid = 1'b1; i_data = 32'h0000_00FF; i_parity = 4'hE;
        cycle();
        i_valid = 1'b0;
        chk("single_err", 32'(err_a), 32'h1);
        chk("single_vec", 32'(vec_a), 32'h1);
        chk("single_cnt", 32'(cnt_a), 32'd1);
        chk("single_irq_early", 32'(irq_a), 32'd0);
        chk("single_halt_ready", 32'(rdy_h), 32'd0);
        cycle();
        chk("single_irq", 32'(irq_a), 32'd1);
        chk("single_hold_data", dat_a, 32'h0000_00FF);
        i_clr = 1'b1;
        cycle();
        i_clr = 1'b0;
        chk("clr_vec", 32'(vec_a), 32'd0);
        chk("clr_cnt", 32'(cnt_a), 32'd0);
        chk("clr_irq_after", 32'(irq_a), 32'd0);
        chk("clr_halt_ready", 32'(rdy_h), 32'd1);

        // Saturation on the 2-bit counter.
        i_data = 32'h0; i_parity = 4'hE;
        for (int n = 0; n < 5; n++) begin
            i_valid = 1'b1;
            cycle();
            chk($sformatf("sat_cnt%0d", n), 32'(cnt_s), 32'(exp_sat[n]));
        end
        i_valid = 1'b0;
        cycle();

        // Clear racing an all-group error while the interrupt is up.
        i_valid = 1'b1; i_data = 32'h0; i_parity = 4'h0; i_clr = 1'b1;
        cycle();
        i_valid = 1'b0; i_clr = 1'b0;
        chk("race_vec", 32'(vec_a), 32'hF);
        chk("race_cnt", 32'(cnt_a), 32'd1);
        chk("race_irq", 32'(irq_a), 32'd1);
        cycle();
        chk("race_irq_hold", 32'(irq_a), 32'd1);

        // Halt on error with valid held high.
        i_valid = 1'b1; i_data = 32'h0; i_parity = 4'h1;
        cycle();
        chk("halt_valid", 32'(vld_h), 32'd1);
        chk("halt_ready", 32'(rdy_h), 32'd0);
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("halted_valid", 32'(vld_h), 32'd0);
            chk("halted_ready", 32'(rdy_h), 32'd0);
        end
        i_valid = 1'b0; i_clr = 1'b1;
        cycle();
        i_clr = 1'b0;
        chk("unhalt_ready", 32'(rdy_h), 32'd1);
        chk("unhalt_vec", 32'(vec_h), 32'd0);
        chk("unhalt_cnt", 32'(cnt_h), 32'd0);
        chk("unhalt_irq", 32'(irq_h), 32'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            i_valid  = ($urandom_range(0, 3) != 0);
            i_data   = $urandom;
            i_parity = good_par(i_data) ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            i_clr    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) i_irq_en = ~i_irq_en;
            cycle();
        end

        // Asynchronous reset during an accepted beat discards it.
        i_clr = 1'b0; i_valid = 1'b1; i_data = 32'h0; i_parity = 4'h0;
        #2 i_rst_n = 1'b0;
        @(posedge i_clk);
        model_reset();
        @(negedge i_clk);
        check_all();
        chk("rst_mid_valid", 32'(vld_a), 32'd0);
        chk("rst_mid_vec", 32'(vec_a), 32'd0);
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        cycle();
        chk("rst_post_valid", 32'(vld_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
